// File: rtl/rvh_l1d_lst_plru.sv
// L1D line-state table: per-set/per-way MESI, tree-PLRU replacement bits and
// way-reservation bits, with multi-port MESI writes and an invalidate-all sweep.
module rvh_l1d_lst_plru #(
    parameter int SET_NUM     = 64,
    parameter int WAY_NUM     = 4,
    parameter int WR_PORT_NUM = 2,
    localparam int SET_W      = $clog2(SET_NUM),
    localparam int WAY_W      = $clog2(WAY_NUM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WR_PORT_NUM-1:0]       wr_en,
    input  logic [WR_PORT_NUM*SET_W-1:0] wr_set,
    input  logic [WR_PORT_NUM*WAY_W-1:0] wr_way,
    input  logic [WR_PORT_NUM*2-1:0]     wr_dat,
    input  logic                         touch_en,
    input  logic [SET_W-1:0]             touch_set,
    input  logic [WAY_W-1:0]             touch_way,
    input  logic [SET_W-1:0]             rd_set,
    output logic [WAY_NUM*2-1:0]         rd_mesi,
    input  logic [SET_W-1:0]             pk_set,
    output logic [WAY_NUM*2-1:0]         pk_mesi,
    output logic [WAY_W-1:0]             pk_victim,
    output logic                         pk_has_inv,
    input  logic                         chk_valid,
    input  logic [SET_W-1:0]             chk_set,
    input  logic [WAY_W-1:0]             chk_way,
    output logic                         chk_ready,
    input  logic                         inv_all_req,
    output logic                         inv_busy,
    output logic                         inv_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [SET_W-1:0]   ptr_reg, ptr_next;
    logic               sweep;
    logic               p0_touch;

    logic [SET_NUM-1:0][WAY_NUM*2-1:0] mesi_all;
    logic [SET_NUM-1:0][WAY_NUM-2:0]   plru_all;
    logic [SET_NUM-1:0][WAY_NUM-1:0]   resv_all;

    // Tree bits use heap numbering: node n at depth d covers ways whose top d bits equal n-2^d.
    function automatic logic [WAY_NUM-2:0] plru_touch(input logic [WAY_NUM-2:0] bits,
                                                       input logic [WAY_W-1:0]   way);
        logic [WAY_NUM-2:0] res;
        res = bits;
        for (int d = 0; d < WAY_W; d++) begin
            for (int i = 0; i < (1 << d); i++) begin
                if (int'(way >> (WAY_W - d)) == i) begin
                    res[(1 << d) + i - 1] = ~way[WAY_W-1-d];
                end
            end
        end
        return res;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAY_NUM-2:0] bits);
        logic [WAY_NUM-1:0] tree;
        logic [WAY_W:0]     node;
        tree = {bits, 1'b0};
        node = (WAY_W+1)'(1);
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            node = {node[WAY_W-1:0], tree[node[WAY_W-1:0]]};
        end
        return node[WAY_W-1:0];
    endfunction

    assign sweep     = (state_reg == ST_SWEEP);
    assign inv_busy  = sweep;
    assign inv_done  = (state_reg == ST_DONE);
    assign p0_touch  = wr_en[0] && (wr_dat[1:0] != 2'd0);
    assign chk_ready = ~sweep & ~resv_all[chk_set][chk_way];
    assign rd_mesi   = mesi_all[rd_set];
    assign pk_mesi   = mesi_all[pk_set];

    always_comb begin
        logic [WAY_W-1:0] inv_way;
        inv_way    = '0;
        pk_has_inv = 1'b0;
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            if (mesi_all[pk_set][w*2 +: 2] == 2'd0) begin
                pk_has_inv = 1'b1;
                inv_way    = WAY_W'(w);
            end
        end
        pk_victim = pk_has_inv ? inv_way : plru_victim(plru_all[pk_set]);
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (inv_all_req) begin
                    state_next = ST_SWEEP;
                    ptr_next   = '0;
                end
            end
            ST_SWEEP: begin
                ptr_next = ptr_reg + 1'b1;
                if (ptr_reg == SET_W'(SET_NUM - 1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    for (genvar gi = 0; gi < SET_NUM; gi++) begin : g_set
        logic [WAY_NUM*2-1:0] mesi_reg, mesi_next;
        logic [WAY_NUM-2:0]   plru_reg, plru_next;
        logic [WAY_NUM-1:0]   resv_reg, resv_next;
        logic                 touch_hit;
        logic [WAY_W-1:0]     touch_sel;

        always_comb begin
            mesi_next = mesi_reg;
            plru_next = plru_reg;
            resv_next = resv_reg;
            touch_hit = 1'b0;
            touch_sel = '0;
            if (sweep) begin
                if (ptr_reg == SET_W'(gi)) begin
                    mesi_next = '0;
                    plru_next = '0;
                    resv_next = '0;
                end
            end else begin
                // Descending port order so the lowest matching port is applied last.
                for (int w = 0; w < WAY_NUM; w++) begin
                    for (int p = WR_PORT_NUM - 1; p >= 0; p--) begin
                        if (wr_en[p] && wr_set[p*SET_W +: SET_W] == SET_W'(gi)
                                     && wr_way[p*WAY_W +: WAY_W] == WAY_W'(w)) begin
                            mesi_next[w*2 +: 2] = wr_dat[p*2 +: 2];
                        end
                    end
                end
                if (chk_valid && chk_ready && chk_set == SET_W'(gi)) begin
                    resv_next[chk_way] = 1'b1;
                end
                if (p0_touch && wr_set[SET_W-1:0] == SET_W'(gi)) begin
                    resv_next[wr_way[WAY_W-1:0]] = 1'b0;
                end
                if (touch_en && touch_set == SET_W'(gi)) begin
                    touch_hit = 1'b1;
                    touch_sel = touch_way;
                end else if (p0_touch && wr_set[SET_W-1:0] == SET_W'(gi)) begin
                    touch_hit = 1'b1;
                    touch_sel = wr_way[WAY_W-1:0];
                end
                if (touch_hit) begin
                    plru_next = plru_touch(plru_reg, touch_sel);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                mesi_reg <= '0;
                plru_reg <= '0;
                resv_reg <= '0;
            end else begin
                mesi_reg <= mesi_next;
                plru_reg <= plru_next;
                resv_reg <= resv_next;
            end
        end

        assign mesi_all[gi] = mesi_reg;
        assign plru_all[gi] = plru_reg;
        assign resv_all[gi] = resv_reg;
    end

endmodule

// File: tb/tb_rvh_l1d_lst_plru.sv
// Bench for rvh_l1d_lst_plru: recency-based reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_rvh_l1d_lst_plru;
    localparam int SET_NUM     = 64;
    localparam int WAY_NUM     = 4;
    localparam int WR_PORT_NUM = 2;
    localparam int SET_W       = 6;
    localparam int WAY_W       = 2;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [WR_PORT_NUM-1:0]       wr_en;
    logic [WR_PORT_NUM*SET_W-1:0] wr_set;
    logic [WR_PORT_NUM*WAY_W-1:0] wr_way;
    logic [WR_PORT_NUM*2-1:0]     wr_dat;
    logic                         touch_en;
    logic [SET_W-1:0]             touch_set;
    logic [WAY_W-1:0]             touch_way;
    logic [SET_W-1:0]             rd_set;
    logic [WAY_NUM*2-1:0]         rd_mesi;
    logic [SET_W-1:0]             pk_set;
    logic [WAY_NUM*2-1:0]         pk_mesi;
    logic [WAY_W-1:0]             pk_victim;
    logic                         pk_has_inv;
    logic                         chk_valid;
    logic [SET_W-1:0]             chk_set;
    logic [WAY_W-1:0]             chk_way;
    logic                         chk_ready;
    logic                         inv_all_req;
    logic                         inv_busy;
    logic                         inv_done;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    rvh_l1d_lst_plru #(
        .SET_NUM(SET_NUM), .WAY_NUM(WAY_NUM), .WR_PORT_NUM(WR_PORT_NUM)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way), .wr_dat(wr_dat),
        .touch_en(touch_en), .touch_set(touch_set), .touch_way(touch_way),
        .rd_set(rd_set), .rd_mesi(rd_mesi),
        .pk_set(pk_set), .pk_mesi(pk_mesi), .pk_victim(pk_victim), .pk_has_inv(pk_has_inv),
        .chk_valid(chk_valid), .chk_set(chk_set), .chk_way(chk_way), .chk_ready(chk_ready),
        .inv_all_req(inv_all_req), .inv_busy(inv_busy), .inv_done(inv_done)
    );

    always #5 clk = ~clk;

    // Reference model: MESI values, last-touch timestamps per way, reservation flags.
    int m_mesi [SET_NUM][WAY_NUM];
    int m_last [SET_NUM][WAY_NUM];
    bit m_resv [SET_NUM][WAY_NUM];
    int m_sweep_left = 0;
    int m_stamp = 0;
    bit m_done = 1'b0;

    task automatic m_clear_set(input int s);
        for (int w = 0; w < WAY_NUM; w++) begin
            m_mesi[s][w] = 0;
            m_last[s][w] = 0;
            m_resv[s][w] = 1'b0;
        end
    endtask

    task automatic model_step();
        int s0, w0, d0, cs, cw;
        bit grant;
        if (rst) begin
            for (int s = 0; s < SET_NUM; s++) m_clear_set(s);
            m_sweep_left = 0;
            m_done = 1'b0;
        end else if (m_sweep_left > 0) begin
            m_clear_set(SET_NUM - m_sweep_left);
            m_sweep_left--;
            if (m_sweep_left == 0) m_done = 1'b1;
        end else begin
            m_stamp++;
            cs = int'(chk_set);
            cw = int'(chk_way);
            grant = chk_valid && !m_resv[cs][cw];
            for (int p = WR_PORT_NUM - 1; p >= 0; p--) begin
                if (wr_en[p])
                    m_mesi[int'(wr_set[p*SET_W +: SET_W])][int'(wr_way[p*WAY_W +: WAY_W])] =
                        int'(wr_dat[p*2 +: 2]);
            end
            s0 = int'(wr_set[SET_W-1:0]);
            w0 = int'(wr_way[WAY_W-1:0]);
            d0 = int'(wr_dat[1:0]);
            if (grant) m_resv[cs][cw] = 1'b1;
            if (wr_en[0] && d0 != 0) m_resv[s0][w0] = 1'b0;
            if (touch_en) m_last[int'(touch_set)][int'(touch_way)] = m_stamp;
            if (wr_en[0] && d0 != 0 && !(touch_en && int'(touch_set) == s0))
                m_last[s0][w0] = m_stamp;
            if (!m_done && inv_all_req) m_sweep_left = SET_NUM;
            m_done = 1'b0;
        end
    endtask

    function automatic int m_pack(input int s);
        logic [WAY_NUM*2-1:0] v;
        v = '0;
        for (int w = 0; w < WAY_NUM; w++) v[w*2 +: 2] = 2'(m_mesi[s][w]);
        return int'(v);
    endfunction

    function automatic int m_has_inv(input int s);
        int r;
        r = 0;
        for (int w = 0; w < WAY_NUM; w++) if (m_mesi[s][w] == 0) r = 1;
        return r;
    endfunction

    // Victim: lowest invalid way, else repeatedly step into the half whose most recent touch is older.
    function automatic int m_victim(input int s);
        int lo, size, half, ml, mr, found;
        found = -1;
        for (int w = WAY_NUM - 1; w >= 0; w--) if (m_mesi[s][w] == 0) found = w;
        if (found >= 0) return found;
        lo = 0;
        size = WAY_NUM;
        while (size > 1) begin
            half = size / 2;
            ml = 0;
            mr = 0;
            for (int i = 0; i < half; i++) begin
                if (m_last[s][lo+i] > ml) ml = m_last[s][lo+i];
                if (m_last[s][lo+half+i] > mr) mr = m_last[s][lo+half+i];
            end
            if (ml > mr) lo = lo + half;
            size = half;
        end
        return lo;
    endfunction

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            cmp("rd_mesi",    int'(rd_mesi),    m_pack(int'(rd_set)));
            cmp("pk_mesi",    int'(pk_mesi),    m_pack(int'(pk_set)));
            cmp("pk_has_inv", int'(pk_has_inv), m_has_inv(int'(pk_set)));
            cmp("pk_victim",  int'(pk_victim),  m_victim(int'(pk_set)));
            cmp("chk_ready",  int'(chk_ready),
                (m_sweep_left == 0 && !m_resv[int'(chk_set)][int'(chk_way)]) ? 1 : 0);
            cmp("inv_busy",   int'(inv_busy),   (m_sweep_left > 0) ? 1 : 0);
            cmp("inv_done",   int'(inv_done),   int'(m_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wr_en       = '0;
        touch_en    = 1'b0;
        chk_valid   = 1'b0;
        inv_all_req = 1'b0;
    endtask

    task automatic wr(input int p, input int s, input int w, input int d);
        wr_en[p]                 = 1'b1;
        wr_set[p*SET_W +: SET_W] = SET_W'(s);
        wr_way[p*WAY_W +: WAY_W] = WAY_W'(w);
        wr_dat[p*2 +: 2]         = 2'(d);
    endtask

    task automatic touch(input int s, input int w);
        touch_en  = 1'b1;
        touch_set = SET_W'(s);
        touch_way = WAY_W'(w);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout: got no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int busy_cnt, done_at, bad, seen;
        clr();
        wr_set = '0; wr_way = '0; wr_dat = '0;
        touch_set = '0; touch_way = '0;
        rd_set = '0; pk_set = '0; chk_set = '0; chk_way = '0;
        rst = 1'b1;
        repeat (3) tick();
        chk_on = 1'b1;
        rst = 1'b0;

        // Reset state across all sets
        bad = 0;
        for (int s = 0; s < SET_NUM; s++) begin
            rd_set = SET_W'(s); pk_set = SET_W'(s);
            chk_set = SET_W'(s); chk_way = WAY_W'(s % WAY_NUM);
            tick();
            if (rd_mesi != '0 || !pk_has_inv || pk_victim != '0 || !chk_ready) bad++;
        end
        cmp("t1_reset_sets", bad, 0);

        // Same target on two ports: port 0 wins; distinct targets both commit
        wr(0, 3, 2, 3); wr(1, 3, 2, 1);
        tick(); clr();
        rd_set = 3; #1;
        cmp("t2_port0_wins", int'(rd_mesi), 'h30);
        wr(0, 3, 0, 2); wr(1, 9, 1, 3);
        tick(); clr();
        rd_set = 3; #1;
        cmp("t2_multi_set3", int'(rd_mesi), 'h32);
        rd_set = 9; #1;
        cmp("t2_multi_set9", int'(rd_mesi), 'h0C);

        // PLRU victim selection in a full set
        for (int w = 0; w < WAY_NUM; w++) begin
            wr(0, 5, w, 2); tick(); clr();
        end
        for (int w = 0; w < WAY_NUM; w++) begin
            touch(5, w); tick(); clr();
        end
        pk_set = 5; #1;
        cmp("t3_has_inv_full", int'(pk_has_inv), 0);
        cmp("t3_victim_0", int'(pk_victim), 0);
        touch(5, 0); tick(); clr(); #1;
        cmp("t3_victim_2", int'(pk_victim), 2);
        touch(5, 3); wr(0, 5, 1, 3); tick(); clr(); #1;
        cmp("t3_touch_wins", int'(pk_victim), 1);
        wr(0, 5, 2, 0); tick(); clr(); #1;
        cmp("t3_inv_has", int'(pk_has_inv), 1);
        cmp("t3_inv_victim", int'(pk_victim), 2);
        cmp("t3_pk_mesi", int'(pk_mesi), 'h8E);

        // Reservations
        chk_valid = 1'b1; chk_set = 7; chk_way = 1; #1;
        cmp("t4_ready_free", int'(chk_ready), 1);
        tick();
        cmp("t4_ready_taken", int'(chk_ready), 0);
        tick();
        cmp("t4_ready_retry", int'(chk_ready), 0);
        chk_valid = 1'b0;
        wr(0, 7, 1, 2); tick(); clr(); #1;
        cmp("t4_ready_cleared", int'(chk_ready), 1);
        chk_valid = 1'b1; chk_way = 3; wr(0, 7, 3, 1); tick(); clr(); #1;
        cmp("t4_clear_wins", int'(chk_ready), 1);
        chk_valid = 1'b1; chk_way = 0; tick(); clr();
        wr(0, 7, 0, 0); tick(); clr(); #1;
        cmp("t4_inv_no_clear", int'(chk_ready), 0);
        wr(1, 7, 0, 3); tick(); clr(); #1;
        cmp("t4_port1_no_clear", int'(chk_ready), 0);

        // Invalidate-all sweep with writes attempted during it
        rd_set = 63; pk_set = 63;
        inv_all_req = 1'b1; tick(); inv_all_req = 1'b0;
        busy_cnt = 0; done_at = 0;
        for (int k = 1; k <= 200; k++) begin
            if (k > 1) tick();
            if (inv_busy) busy_cnt++;
            if (k == 2) begin
                wr(0, 63, 0, 3); wr(1, 62, 1, 3); touch(63, 2);
                chk_valid = 1'b1; chk_set = 0; chk_way = 0; #1;
                cmp("t5_ready_in_sweep", int'(chk_ready), 0);
            end
            if (k == 3) clr();
            if (inv_done) begin
                done_at = k;
                break;
            end
        end
        clr();
        cmp("t5_busy_cycles", busy_cnt, 64);
        cmp("t5_done_cycle", done_at, 65);
        tick();
        cmp("t5_done_pulse", int'(inv_done), 0);
        bad = 0;
        for (int s = 0; s < SET_NUM; s++) begin
            rd_set = SET_W'(s); chk_set = SET_W'(s); chk_way = 0; #1;
            if (rd_mesi != '0 || !chk_ready) bad++;
        end
        cmp("t5_all_clear", bad, 0);
        tick();

        // Reset in the middle of a sweep
        wr(0, 40, 2, 2); touch(40, 1); tick(); clr();
        chk_valid = 1'b1; chk_set = 40; chk_way = 2; tick(); clr(); #1;
        cmp("t6_pre_resv", int'(chk_ready), 0);
        inv_all_req = 1'b1; tick(); inv_all_req = 1'b0;
        repeat (20) tick();
        cmp("t6_busy_at_20", int'(inv_busy), 1);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        seen = 0;
        repeat (80) begin
            tick();
            if (inv_done || inv_busy) seen++;
        end
        cmp("t6_no_done", seen, 0);
        rd_set = 40; chk_set = 40; chk_way = 2; #1;
        cmp("t6_mesi_reset", int'(rd_mesi), 0);
        cmp("t6_resv_reset", int'(chk_ready), 1);
        for (int w = 0; w < WAY_NUM; w++) begin
            wr(1, 40, w, 1); tick(); clr();
        end
        pk_set = 40; #1;
        cmp("t6_plru_reset", int'(pk_victim), 0);
        tick();

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
